bitop_pipe: RTL and testbench
=============================

# bitop_pipe

Parametrised multi-lane bitwise operator pipeline: accepts LANES operand pairs per beat with a per-beat opcode and returns the registered result DEPTH cycles later. Unlike the fixed two-stage XOR block, it supports selectable operations, a configurable pipeline depth and full valid/ready backpressure with bubble collapsing. It sits between the operand staging logic and any result consumer that may stall.

## Interface
- W, 20, lane data width in bits (1..64)
- LANES, 2, number of independent lanes per beat (1..8)
- DEPTH, 2, pipeline register stages from input to output (1..8)
- CNT_W, 16, width of the delivered-result counter
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat present on a/b/op
- in_ready  output  1  block accepts the beat this cycle
- op  input  2  operation: 0 XOR, 1 AND, 2 OR, 3 XNOR
- a  input  LANES*W  operand A, lane i at bits [i*W +: W]
- b  input  LANES*W  operand B, same packing
- out_valid  output  1  result beat present on y/out_op
- out_ready  input  1  consumer takes the beat this cycle
- y  output  LANES*W  per-lane result
- out_op  output  2  opcode that produced y
- result_cnt  output  CNT_W  number of completed output handshakes

## Operation
- Input handshake: beat accepted when in_valid && in_ready. Result a op b is computed per lane at acceptance and loaded into stage 0 with its opcode and a valid bit.
- Stages 0..DEPTH-1 each hold {valid, y, op}. The last stage drives out_valid/y/out_op.
- Advance rule: last stage drains when out_valid && out_ready. Stage k loads from stage k-1 (or from the input for k=0) when stage k is empty or draining. This collapses bubbles: a stalled output never blocks earlier empty stages.
- in_ready = !valid[0] || stage 0 loading onward. The combinational ready chain spans all stages.
- Data registers of stage k update only when stage k loads a valid beat. y/out_op therefore hold their last value while out_valid is low; no update occurs on bubbles.
- result_cnt increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- XNOR is the bitwise complement of XOR within W bits per lane. Lanes are fully independent; no cross-lane carry.
- Reset (any time, including mid-stall): all valid bits 0, y = 0, out_op = 0, result_cnt = 0. In-flight beats are discarded. in_ready = 1 from the first cycle after reset deasserts.

## Timing
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH register stages with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Capacity: DEPTH beats in flight. With out_ready held low, in_ready drops after DEPTH accepts.
- Simultaneous drain and accept with the pipe full: both occur in the same cycle and occupancy is unchanged.
- out_valid, once asserted, stays asserted with y/out_op stable until out_ready=1.
- in_valid without in_ready: the beat is not consumed; the source holds it.

## Structure
- Package bitop_pkg holds the opcode typedef/localparams (OP_XOR=0, OP_AND=1, OP_OR=2, OP_XNOR=3) and the lane-compute function bitop_f(op, a, b).
- Sub-module bitop_stage: one pipeline register {valid, y, op} with load/drain ports, instantiated DEPTH times via generate.
- Top level contains the input compute, ready chain and result counter.

## Test plan
- Defaults, lane0 a=0xF0F0F b=0x0FF0F, ops 0..3 back-to-back with out_ready=1 -> y lane0 = 0xFF000, 0x00F0F, 0xFFF0F, 0x00FFF on consecutive cycles starting DEPTH-1 cycles after the first accept; result_cnt=4.
- out_ready=0, stream beats -> exactly DEPTH accepted, then in_ready=0. out_ready=1 -> all beats emerge in order, none lost or duplicated.
- Single beat then idle -> y/out_op hold the value after the handshake, and out_valid=0 for the following cycles.
- Bubble collapse: accept beat, idle 1 cycle, accept beat, out_ready=0 -> both beats occupy the last two stages, and in_ready stays 1 while DEPTH>2.
- Assert rst mid-stall with 2 beats in flight -> out_valid=0, y=0, result_cnt=0 immediately. No stale beat appears after release.
- CNT_W=4, 17 handshakes -> result_cnt wraps to 1.

Source files
------------

// File: rtl/bitop_pkg.sv
// bitop_pkg: opcode encoding and the per-lane bitwise compute function.
package bitop_pkg;
  typedef enum logic [1:0] {OP_XOR = 2'd0, OP_AND = 2'd1, OP_OR = 2'd2, OP_XNOR = 2'd3} op_e;
  function automatic logic [63:0] bitop_f(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    return op == OP_XOR ? a ^ b : op == OP_AND ? a & b : op == OP_OR ? a | b : ~(a ^ b);
  endfunction
endpackage

// File: rtl/bitop_stage.sv
// bitop_stage: one pipeline register {valid, y, op} that refills whenever empty or draining.
module bitop_stage #(
  parameter int YW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          drain,
  input  logic          in_valid,
  input  logic [YW-1:0] in_y,
  input  logic [1:0]    in_op,
  output logic          ready,
  output logic          valid,
  output logic [YW-1:0] y,
  output logic [1:0]    op
);
  logic          valid_d, valid_q;
  logic [YW-1:0] y_d, y_q;
  logic [1:0]    op_d, op_q;
  always_comb begin
    ready   = !valid_q || drain;
    valid_d = ready ? in_valid : valid_q;
    y_d     = ready && in_valid ? in_y : y_q;
    op_d    = ready && in_valid ? in_op : op_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      op_q    <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      op_q    <= op_d;
    end
  assign valid = valid_q;
  assign y     = y_q;
  assign op    = op_q;
endmodule

// File: rtl/bitop_pipe.sv
// bitop_pipe: multi-lane bitwise operator pipeline with valid/ready backpressure and bubble collapsing.
module bitop_pipe
  import bitop_pkg::*;
#(
  parameter int W     = 20,
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] y,
  output logic [1:0]         out_op,
  output logic [CNT_W-1:0]   result_cnt
);
  logic [LANES*W-1:0] y_in;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  // Index 0 is the input side; index k+1 is the output of stage k.
  logic               go  [DEPTH+1];
  logic               v   [DEPTH+1];
  logic [LANES*W-1:0] ys  [DEPTH+1];
  logic [1:0]         ops [DEPTH+1];
  always_comb begin
    y_in = '0;
    for (int i = 0; i < LANES; i++)
      y_in[i*W +: W] = W'(bitop_f(op, 64'(a[i*W +: W]), 64'(b[i*W +: W])));
  end
  assign v[0]      = in_valid;
  assign ys[0]     = y_in;
  assign ops[0]    = op;
  assign go[DEPTH] = out_ready;
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      bitop_stage #(.YW(LANES*W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .drain   (go[k+1]),
        .in_valid(v[k]),
        .in_y    (ys[k]),
        .in_op   (ops[k]),
        .ready   (go[k]),
        .valid   (v[k+1]),
        .y       (ys[k+1]),
        .op      (ops[k+1])
      );
    end
  endgenerate
  assign in_ready  = go[0];
  assign out_valid = v[DEPTH];
  assign y         = ys[DEPTH];
  assign out_op    = ops[DEPTH];
  always_comb cnt_d = out_valid && out_ready ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign result_cnt = cnt_q;
endmodule

// File: tb/tb_bitop_pipe.sv
// tb_bitop_pipe: directed checks of compute, latency, backpressure, bubble collapse, reset and counter wrap.
module tb_bitop_pipe;
  localparam int W = 20, LANES = 2, DEPTH = 3, CNT_W = 4;
  logic               clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0]         op = '0, out_op;
  logic [LANES*W-1:0] a = '0, b = '0, y;
  logic [CNT_W-1:0]   result_cnt;
  int tests = 0, fails = 0;
  bitop_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_op(out_op), .result_cnt(result_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  logic [39:0] exp_y [4] = '{40'hEDCBA_FF000, 40'h12345_00F0F, 40'hFFFFF_FFF0F, 40'h12345_00FFF};
  int acc;
  logic take;
  initial begin
    cyc();
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_out_op", 64'(out_op), 64'(0));
    chk("rst_cnt", 64'(result_cnt), 64'(0));
    rst = 1'b0;
    cyc();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    a = {20'h12345, 20'hF0F0F};
    b = {20'hFFFFF, 20'h0FF0F};
    for (int i = 0; i < 6; i++) begin
      in_valid = i < 4;
      op = 2'(i);
      cyc();
      if (i >= 2) begin
        chk("ops_valid", 64'(out_valid), 64'(1));
        chk("ops_y", 64'(y), 64'(exp_y[i-2]));
        chk("ops_op", 64'(out_op), 64'(i-2));
      end
    end
    cyc();
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_y_hold", 64'(y), 64'(40'h12345_00FFF));
    chk("idle_op_hold", 64'(out_op), 64'(3));
    chk("ops_cnt", 64'(result_cnt), 64'(4));
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 2'd0;
    b = '0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      a = {20'h0, 20'(acc)};
      #1;
      take = in_ready;
      cyc();
      if (take) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'(DEPTH));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_hold_valid", 64'(out_valid), 64'(1));
    chk("bp_hold_y", 64'(y), 64'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk("bp_drain_valid", 64'(out_valid), 64'(1));
      chk("bp_drain_y", 64'(y), 64'(j));
      cyc();
    end
    chk("bp_empty", 64'(out_valid), 64'(0));
    chk("bp_cnt", 64'(result_cnt), 64'(7));
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = {20'h0, 20'h00111};
    cyc();
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1;
    a = {20'h0, 20'h00222};
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("bub_valid", 64'(out_valid), 64'(1));
    chk("bub_y", 64'(y), 64'(40'h00111));
    chk("bub_in_ready", 64'(in_ready), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_y", 64'(y), 64'(0));
    chk("mid_rst_cnt", 64'(result_cnt), 64'(0));
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    for (int j = 0; j < DEPTH + 1; j++) begin
      cyc();
      chk("post_rst_no_stale", 64'(out_valid), 64'(0));
    end
    op = 2'd2;
    for (int c = 0; c < 20; c++) begin
      in_valid = c < 17;
      a = {20'h0, 20'(c)};
      cyc();
      if (c >= DEPTH - 1 && c < 16 + DEPTH) chk("wrap_stream_y", 64'(y), 64'(c - (DEPTH - 1)));
    end
    in_valid = 1'b0;
    cyc();
    chk("wrap_cnt", 64'(result_cnt), 64'(1));
    chk("wrap_empty", 64'(out_valid), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
